// File: rtl/scene_query_reduce.sv
// scene_query_reduce: broadcasts each query point to NUM_OBJ SDF engines.
// Per-object FIFOs collect the in-order results. A registered compare tree
// then reduces the masked set to a min (union) or max (intersection)
// distance and reports the index of the winning object.
module scene_query_reduce #(
  parameter int NUM_OBJ = 4,
  parameter int DEPTH   = 8,
  localparam int L      = $clog2(NUM_OBJ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  output logic                  in_ready,
  input  logic [95:0]           pos,
  input  logic [NUM_OBJ-1:0]    obj_mask,
  input  logic                  mode,
  output logic                  sdf_valid_o,
  output logic [95:0]           sdf_pos_o,
  input  logic [32*NUM_OBJ-1:0] sdf_dist,
  input  logic [NUM_OBJ-1:0]    sdf_valid,
  output logic [31:0]           closestDistance,
  output logic [3:0]            closest_id,
  output logic                  valid_out,
  output logic                  err_overflow
);

  // The tree is padded up to a power of two. Pad lanes are always invalid.
  localparam int P  = 1 << L;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = NUM_OBJ + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic        en;
    logic [3:0]  id;
    logic [31:0] d;
  } lane_t;

  // Identity element of the reduction. A masked lane carries this value.
  function automatic logic [31:0] ident_of(input logic md);
    return md ? 32'h8000_0000 : 32'h7FFF_FFFF;
  endfunction

  // Lane a always holds lower ids than lane b, so on a tie a is kept. When
  // neither lane is valid, a is also kept.
  function automatic lane_t pick(input lane_t a, input lane_t b, input logic md);
    lane_t r;
    r = a;
    if (b.en && !a.en) begin
      r = b;
    end else if (a.en && b.en) begin
      if (md) begin
        if ($signed(b.d) > $signed(a.d)) r = b;
      end else begin
        if ($signed(b.d) < $signed(a.d)) r = b;
      end
    end
    return r;
  endfunction

  logic          accept;
  logic          pop;
  logic [CW-1:0] out_cnt;

  logic [31:0]        res_mem [NUM_OBJ][DEPTH];
  logic [AW-1:0]      res_wp  [NUM_OBJ];
  logic [AW-1:0]      res_rp  [NUM_OBJ];
  logic [CW-1:0]      res_cnt [NUM_OBJ];
  logic [NUM_OBJ-1:0] res_full;
  logic [NUM_OBJ-1:0] res_empty;
  logic [NUM_OBJ-1:0] res_push;

  logic [SW-1:0] side_mem [DEPTH];
  logic [AW-1:0] side_wp;
  logic [AW-1:0] side_rp;
  logic [CW-1:0] side_cnt;
  logic [SW-1:0] side_head;

  lane_t lane0 [P];
  lane_t tr    [L+1][P];
  logic  [L:0] pv;
  logic  [L:0] md_r;

  assign in_ready = (out_cnt < DEPTH_C);
  assign accept   = valid_in && in_ready;

  // FIFO status, push qualification and the all-heads-present pop condition
  always_comb begin
    res_full  = '0;
    res_empty = '0;
    res_push  = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      res_full[i]  = (res_cnt[i] == DEPTH_C);
      res_empty[i] = (res_cnt[i] == '0);
      res_push[i]  = sdf_valid[i] && !res_full[i];
    end
    side_head = side_mem[side_rp];
    pop       = !(|res_empty) && (side_cnt != '0);
  end

  // Register the query point and pulse the broadcast strobe once per accept
  always_ff @(posedge clk) begin
    if (rst) begin
      sdf_valid_o <= 1'b0;
      sdf_pos_o   <= '0;
    end else begin
      sdf_valid_o <= accept;
      if (accept) sdf_pos_o <= pos;
    end
  end

  // Track the queries accepted but not yet popped. This count bounds every FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt <= '0;
    end else if (accept && !pop) begin
      out_cnt <= out_cnt + CW'(1);
    end else if (!accept && pop) begin
      out_cnt <= out_cnt - CW'(1);
    end
  end

  // FIFO storage. It needs no reset because the pointers decide what is live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (res_push[i]) res_mem[i][res_wp[i]] <= sdf_dist[32*i +: 32];
    end
    if (accept) side_mem[side_wp] <= {obj_mask, mode};
  end

  // FIFO pointers and counts, and the sticky overflow flag for dropped results
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        res_wp[i]  <= '0;
        res_rp[i]  <= '0;
        res_cnt[i] <= '0;
      end
      side_wp      <= '0;
      side_rp      <= '0;
      side_cnt     <= '0;
      err_overflow <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        if (res_push[i]) res_wp[i] <= res_wp[i] + AW'(1);
        if (pop)         res_rp[i] <= res_rp[i] + AW'(1);
        case ({res_push[i], pop})
          2'b10:   res_cnt[i] <= res_cnt[i] + CW'(1);
          2'b01:   res_cnt[i] <= res_cnt[i] - CW'(1);
          default: res_cnt[i] <= res_cnt[i];
        endcase
      end
      if (accept) side_wp <= side_wp + AW'(1);
      if (pop)    side_rp <= side_rp + AW'(1);
      case ({accept, pop})
        2'b10:   side_cnt <= side_cnt + CW'(1);
        2'b01:   side_cnt <= side_cnt - CW'(1);
        default: side_cnt <= side_cnt;
      endcase
      if (|(sdf_valid & res_full)) err_overflow <= 1'b1;
    end
  end

  // Build the stage-0 lanes from the FIFO heads, replacing masked lanes with the identity
  always_comb begin
    for (int j = 0; j < P; j++) begin
      lane0[j].en = 1'b0;
      lane0[j].id = 4'(j);
      lane0[j].d  = ident_of(side_head[0]);
    end
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (side_head[i+1]) begin
        lane0[i].en = 1'b1;
        lane0[i].d  = res_mem[i][res_rp[i]];
      end
    end
  end

  // Registered compare tree. Each level updates only when fed, so the last result is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv   <= '0;
      md_r <= '0;
      for (int k = 0; k <= L; k++) begin
        for (int j = 0; j < P; j++) tr[k][j] <= '0;
      end
    end else begin
      pv[0] <= pop;
      if (pop) begin
        md_r[0] <= side_head[0];
        for (int j = 0; j < P; j++) tr[0][j] <= lane0[j];
      end
      for (int k = 1; k <= L; k++) begin
        pv[k] <= pv[k-1];
        if (pv[k-1]) begin
          md_r[k] <= md_r[k-1];
          for (int j = 0; j < (P >> k); j++) begin
            tr[k][j] <= pick(tr[k-1][2*j], tr[k-1][2*j+1], md_r[k-1]);
          end
        end
      end
    end
  end

  assign closestDistance = tr[L][0].d;
  assign closest_id      = tr[L][0].id;
  assign valid_out       = pv[L];

endmodule

// File: doc/scene_query_reduce.md
# scene_query_reduce

Parametrised scene-query stage for the ray marcher. It broadcasts each query point to `NUM_OBJ` SDF engines with independent fixed latencies, aligns their in-order results in per-object FIFOs, and reduces the masked set through a registered compare tree. It returns the closest (union) or farthest (intersection) signed distance together with the winning object index. It replaces single-object selection in the march loop and adds multi-object reduction, credit-based flow control and an overflow flag.

## Interface
Parameters:
- `NUM_OBJ`, 4: number of SDF engines; legal range 1..16.
- `DEPTH`, 8: per-object result FIFO depth and maximum outstanding queries; power of 2, at least 2.
- `L`, derived: `$clog2(NUM_OBJ)`, the number of tree levels (0 when `NUM_OBJ`=1).

Ports (clock and reset: one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `valid_in`  in  1  query offered this cycle.
- `in_ready`  out  1  query accepted when `valid_in && in_ready`.
- `pos`  in  96  vec3 query point, three Q8.24 `fp` values.
- `obj_mask`  in  NUM_OBJ  objects that take part in the reduction.
- `mode`  in  1  0 = union (min), 1 = intersection (max).
- `sdf_valid_o`  out  1  broadcast query strobe to all engines.
- `sdf_pos_o`  out  96  registered copy of `pos`.
- `sdf_dist`  in  32·NUM_OBJ  per-engine signed Q8.24 distance.
- `sdf_valid`  in  NUM_OBJ  per-engine result strobe.
- `closestDistance`  out  32  reduced signed distance.
- `closest_id`  out  4  index of the winning object.
- `valid_out`  out  1  one-cycle result strobe.
- `err_overflow`  out  1  sticky; set when a result arrives at a full FIFO.

## Operation
- **Accept.** On accept, `pos` is registered to `sdf_pos_o` and `sdf_valid_o` pulses high for one cycle. Every query goes to all engines, regardless of `obj_mask`.
- **Side FIFO.** `{obj_mask, mode}` is pushed into a DEPTH-entry side FIFO on accept.
- **Result FIFOs.** Each `sdf_valid[i]` pushes `sdf_dist[i]` into FIFO i. Engines return results in order, so the FIFO heads always belong to the same query.
- **Overflow.** A push to a full FIFO drops the data and sets `err_overflow`. `err_overflow` clears only on `rst`.
- **Outstanding counter.**
  - Increments on accept and decrements on pop; unchanged when both happen in the same cycle.
  - `in_ready = (outstanding < DEPTH)`. Zero-bubble acceptance is allowed when `outstanding`=DEPTH−1.
- **Pop.** A pop happens in any cycle where all NUM_OBJ FIFOs and the side FIFO are non-empty. It reads all heads at once.
- **Stage 0 (registered).** Each lane gets `{dist, id=i, en=mask[i]}`.
  - A lane with `en`=0 is replaced by the identity value: 0x7FFFFFFF for union, 0x80000000 for intersection.
  - Lane valid is `en`.
- **Tree level k.** Pairs are combined with a registered signed compare.
  - Union keeps the smaller value; intersection keeps the larger value.
  - On equal values the lower id wins.
  - An invalid lane always loses; combined valid is the OR of both lanes.
- **Empty mask.** If `obj_mask`=0, the result is `closestDistance` = identity value, `closest_id`=0, and `valid_out` still pulses.
- **Non-power-of-two counts.** When NUM_OBJ is not a power of 2, the tree is padded with invalid lanes.
- **Arithmetic.** All comparisons are signed 32-bit. There is no arithmetic on distances, so no saturation or rounding is needed.

## Timing
- **Reset values.** All outputs are 0 except `in_ready`=1; `err_overflow`=0. All FIFOs, the counter and the pipeline valids are cleared.
- **Reset mid-operation.** In-flight results are discarded. Engines share `rst`, so no stale results arrive afterwards.
- **Broadcast latency.** Accept in cycle t → `sdf_valid_o`=1 in cycle t+1.
- **Result latency.** An engine result strobed in cycle a is visible at the FIFO head in cycle a+1.
- **Pop to output.** A pop in cycle p → `valid_out` in cycle p+1+L, with `closestDistance` and `closest_id` valid in the same cycle and held until the next result.
- **End-to-end latency.** With engine latency Λ_max (the largest engine latency), total latency = 1 + Λ_max + 1 + 1 + L cycles from accept.
- **Throughput.** One query per cycle when DEPTH > Λ_max + 2. Otherwise `in_ready` throttles.
- **No backpressure downstream.** `valid_out` is a pulse and must be consumed.

## Test plan
- **Union.** NUM_OBJ=4, all engines Λ=2. Query with `mask`=4'b1111, `mode`=0, distances {0x01000000, 0x00400000, 0xFF000000, 0x00800000} → `closestDistance`=0xFF000000, `closest_id`=2, latency 5+L=7.
- **Intersection with ties.** Same distances with `mode`=1 → 0x01000000, id 0. Then distances {0x00400000, 0x00400000, 0, 0} → id 0 (tie, lowest index wins).
- **Masking.** `mask`=4'b0100 → id 2 and its distance. `mask`=0 with `mode`=0 → 0x7FFFFFFF, id 0, `valid_out` still pulses.
- **Skewed latencies.** Engine latencies {1, 3, 5, 2} and 20 back-to-back queries with DEPTH=8 → results in order, one per cycle after fill, `in_ready` never drops, `err_overflow`=0.
- **Throttling.** Λ=10 with DEPTH=4 → `in_ready` low after 4 outstanding queries, no data loss, outputs in order.
- **Overflow and reset.** Inject a stray `sdf_valid[1]` pulse while FIFO 1 is full → `err_overflow`=1 and sticky. Assert `rst` mid-stream → all outputs at reset values next cycle, `in_ready`=1, and a subsequent query completes correctly.
